// File: rtl/ysyx_24100012_alu_pkg.sv
// ysyx_24100012_alu_pkg
//   Shared definitions for the ALU and its arbiter:
//   - ALU op codes, encoded {funct7[5], funct3}
//   - arbiter FSM state type
//   - helper that identifies shift ops from funct3
package ysyx_24100012_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

  function automatic logic is_shift_op(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/ysyx_24100012_alu.sv
// ysyx_24100012_alu
//   Purely combinational integer ALU.
//   Ports:
//     i_a, i_b  [DATA_WIDTH-1:0]  operands
//     i_op      [OP_W-1:0]        op code {funct7[5], funct3}
//     o_res     [DATA_WIDTH-1:0]  result; unknown op codes yield 0
module ysyx_24100012_alu
  import ysyx_24100012_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_W       = 4
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]       i_op,
  output logic [DATA_WIDTH-1:0] o_res
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_res = '0;
    case (i_op)
      ALU_ADD:  o_res = i_a + i_b;
      ALU_SUB:  o_res = i_a - i_b;
      ALU_SLL:  o_res = i_a << w_shamt;
      ALU_SLT:  o_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_res = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_res = i_a ^ i_b;
      ALU_SRL:  o_res = i_a >> w_shamt;
      ALU_SRA:  o_res = DATA_WIDTH'($signed(i_a) >>> w_shamt);
      ALU_OR:   o_res = i_a | i_b;
      ALU_AND:  o_res = i_a & i_b;
      default:  o_res = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100012_rr_pick.sv
// ysyx_24100012_rr_pick
//   Combinational round-robin picker: first asserted request found when
//   scanning upward from i_ptr, wrapping past N_REQ-1 to 0.
//   Ports:
//     i_req    [N_REQ-1:0]  request vector
//     i_ptr    [IDX_W-1:0]  highest-priority index (must be < N_REQ)
//     o_grant  [N_REQ-1:0]  one-hot grant, zero when no request
//     o_idx    [IDX_W-1:0]  index of the granted request
//     o_any                 some request was granted
module ysyx_24100012_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int unsigned w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/ysyx_24100012_alu_arbiter.sv
// ysyx_24100012_alu_arbiter
//   Shares the core's single ALU between N_REQ requesters: round-robin
//   grant, operand capture, one registered execute stage and a held
//   valid/ready response. Handshake at cycle N gives resp_valid at N+2.
//   Ports:
//     clk, rst                     clock; asynchronous active-low reset
//     req_valid/req_ready [N_REQ]  per-requester handshake (ready one-hot or 0)
//     req_a, req_b                 operands, requester i in slice i
//     req_op                       op code per requester
//     resp_valid/resp_ready        result handshake, result held until taken
//     resp_data, resp_id           result and owning requester
//     perf_grant_cnt [N_REQ*32]    grants per requester
//     perf_stall_cnt [32]          cycles with a request pending but none accepted
//   Macro YSYX_24100012_ALU_ARB_PERF_EN builds the perf counters; when it is
//   undefined the perf ports are tied to 0.
module ysyx_24100012_alu_arbiter
  import ysyx_24100012_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 2,
  parameter int OP_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [N_REQ*OP_W-1:0]        req_op,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic [$clog2(N_REQ)-1:0]     resp_id,
  output logic [N_REQ*32-1:0]          perf_grant_cnt,
  output logic [31:0]                  perf_stall_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SH_MASK = DATA_WIDTH'((64'd1 << SHW) - 64'd1);

  arb_state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_ptr;
  logic [DATA_WIDTH-1:0]   r_a, r_b;
  logic [OP_W-1:0]         r_op;
  logic [IDX_W-1:0]        r_id;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic [IDX_W-1:0]        r_resp_id;

  logic [N_REQ-1:0]        w_grant;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_any;
  logic                    w_arb_en;
  logic                    w_hs;
  logic [DATA_WIDTH-1:0]   w_sel_a, w_sel_b, w_b_capt;
  logic [OP_W-1:0]         w_sel_op;
  logic [DATA_WIDTH-1:0]   w_alu_res;

  ysyx_24100012_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  ysyx_24100012_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_W       (OP_W)
  ) u_alu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_res (w_alu_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = w_hs ? S_EXEC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: arbitration is open in IDLE, and in RESP on the cycle the
  // held result is consumed, so back-to-back ops run at one per 2 cycles.
  always_comb begin
    w_arb_en  = (r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready);
    w_hs      = w_arb_en && w_any;
    req_ready = w_arb_en ? w_grant : '0;
  end

  // Payload of the granted requester; shift amounts are trimmed at capture.
  always_comb begin
    w_sel_a  = req_a[w_idx*DATA_WIDTH +: DATA_WIDTH];
    w_sel_b  = req_b[w_idx*DATA_WIDTH +: DATA_WIDTH];
    w_sel_op = req_op[w_idx*OP_W +: OP_W];
    w_b_capt = is_shift_op(w_sel_op[2:0]) ? (w_sel_b & SH_MASK) : w_sel_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_id  <= '0;
      r_ptr <= '0;
    end else if (w_hs) begin
      r_a   <= w_sel_a;
      r_b   <= w_b_capt;
      r_op  <= w_sel_op;
      r_id  <= w_idx;
      r_ptr <= (w_idx == IDX_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
    end else begin
      if (r_state == S_EXEC) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_alu_res;
        r_resp_id    <= r_id;
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;

`ifdef YSYX_24100012_ALU_ARB_PERF_EN
  logic [31:0] r_grant_cnt [N_REQ];
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_hs && w_grant[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
      if ((|req_valid) && !(|req_ready)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) perf_grant_cnt[i*32 +: 32] = r_grant_cnt[i];
  end
  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_grant_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_24100012_alu_arbiter.sv
// Bench for ysyx_24100012_alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model (queue of pending results, round-robin pointer,
// grant/stall tallies).
module tb_ysyx_24100012_alu_arbiter;

  localparam int DW = 32;
  localparam int N  = 2;
  localparam int OW = 4;
  localparam int IW = $clog2(N);

`ifdef YSYX_24100012_ALU_ARB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a = '0;
  logic [N*DW-1:0]   req_b = '0;
  logic [N*OW-1:0]   req_op = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DW-1:0]     resp_data;
  logic [IW-1:0]     resp_id;
  logic [N*32-1:0]   perf_grant_cnt;
  logic [31:0]       perf_stall_cnt;

  ysyx_24100012_alu_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (N),
    .OP_W       (OW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_op         (req_op),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_id        (resp_id),
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the op table.
  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] op);
    int sh;
    sh = int'(b % DW);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: return (a < b) ? 1 : 0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return DW'($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return '0;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [DW-1:0] d;
    int            id;
    int            due;
  } rsp_t;

  rsp_t        mq[$];
  rsp_t        m_new;
  int          m_ptr = 0;
  int          m_cyc = 0;
  int unsigned m_gcnt[N];
  int unsigned m_stall = 0;
  logic        m_ev;
  logic        m_allow;
  logic [N-1:0] m_eg;
  int          m_g;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      m_ptr   = 0;
      m_cyc   = 0;
      m_stall = 0;
      foreach (m_gcnt[i]) m_gcnt[i] = 0;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", 64'(resp_data), 64'd0);
      chk("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
    end else begin
      m_cyc++;
      m_ev = (mq.size() > 0) && (mq[0].due <= m_cyc);
      chk("resp_valid", 64'(resp_valid), 64'(m_ev));
      if (m_ev) begin
        chk("resp_data", 64'(resp_data), 64'(mq[0].d));
        chk("resp_id", 64'(resp_id), 64'(mq[0].id));
      end
      for (int i = 0; i < N; i++)
        chk("perf_grant_cnt", 64'(perf_grant_cnt[i*32 +: 32]), PERF_ON ? 64'(m_gcnt[i]) : 64'd0);
      chk("perf_stall_cnt", 64'(perf_stall_cnt), PERF_ON ? 64'(m_stall) : 64'd0);

      // The ALU is free when nothing is pending, or the pending result leaves now.
      m_allow = (mq.size() == 0) || (m_ev && resp_ready);
      m_eg = '0;
      m_g  = -1;
      if (m_allow) begin
        for (int k = 0; k < N; k++) begin
          if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        end
      end
      if (m_g >= 0) m_eg[m_g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(m_eg));

      if ((|req_valid) && m_g < 0) m_stall++;
      if (m_ev && resp_ready) void'(mq.pop_front());
      if (m_g >= 0) begin
        m_new.d   = ref_alu(req_a[m_g*DW +: DW], req_b[m_g*DW +: DW], req_op[m_g*OW +: OW]);
        m_new.id  = m_g;
        m_new.due = m_cyc + 2;
        mq.push_back(m_new);
        m_gcnt[m_g]++;
        m_ptr = (m_g + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] op);
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_op[i*OW +: OW] = op;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_ready(input int i, input string nm);
    bit got;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    if (!got) chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
  endtask

  // Called in the cycle after the handshake; checks latency, data and id.
  task automatic wait_resp(input logic [DW-1:0] exp_d, input int exp_id, input string nm);
    bit got;
    int n;
    got = 0;
    n   = 1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
      else n++;
    end
    if (!got) chk({nm, "_resp_timeout"}, 64'd0, 64'd1);
    else begin
      chk({nm, "_latency"}, 64'(n), 64'd2);
      chk({nm, "_data"}, 64'(resp_data), 64'(exp_d));
      chk({nm, "_id"}, 64'(resp_id), 64'(exp_id));
    end
  endtask

  task automatic do_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] op, input logic [DW-1:0] exp_d, input string nm);
    set_req(i, a, b, op);
    req_valid[i] = 1'b1;
    wait_ready(i, nm);
    tick();
    req_valid[i] = 1'b0;
    wait_resp(exp_d, i, nm);
    tick();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return DW'($urandom_range(0, 40));
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [DW-1:0] t_d[4];
  int            t_id[4];
  int            t_n;
  logic [N-1:0]  hs;

  initial begin
    do_reset();

    // T2: single add
    resp_ready = 1'b1;
    do_op(0, 32'd5, 32'd7, 4'b0000, 32'd12, "t2_add");

    // T1: reset while in EXEC; the captured op must never respond
    set_req(0, 32'd9, 32'd9, 4'b0000);
    req_valid[0] = 1'b1;
    wait_ready(0, "t1");
    tick();
    req_valid[0] = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t1_valid_in_rst", 64'(resp_valid), 64'd0);
    chk("t1_data_in_rst", 64'(resp_data), 64'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t1_no_resp", 64'(resp_valid), 64'd0);
    end
    tick();

    // T3: contention, grants alternate
    set_req(0, 32'd1, 32'd1, 4'b0000);
    set_req(1, 32'd10, 32'd3, 4'b1000);
    req_valid = 2'b11;
    t_n = 0;
    for (int k = 0; k < 40 && t_n < 4; k++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        t_d[t_n]  = resp_data;
        t_id[t_n] = int'(resp_id);
        t_n++;
      end
    end
    chk("t3_count", 64'(t_n), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_id", 64'(t_id[k]), 64'(k % 2));
      chk("t3_data", 64'(t_d[k]), (k % 2) ? 64'd7 : 64'd2);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();

    // T4: backpressure with 0-1, pending req1 granted on release
    resp_ready = 1'b0;
    set_req(0, 32'd0, 32'd1, 4'b1000);
    req_valid[0] = 1'b1;
    wait_ready(0, "t4");
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 32'd2, 32'd3, 4'b0000);
    req_valid[1] = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(resp_valid), 64'd1);
      chk("t4_hold_data", 64'(resp_data), 64'hFFFF_FFFF);
      chk("t4_hold_id", 64'(resp_id), 64'd0);
      chk("t4_no_ready", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_same_cycle_grant", 64'(req_ready), 64'b10);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(32'd5, 1, "t4_req1");
    tick();

    // T5: arithmetic edges
    do_op(0, 32'h8000_0000, 32'h21, 4'b1101, 32'hC000_0000, "t5_sra");
    do_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, "t5_slt");
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd0, "t5_sltu");
    do_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, "t5_add_wrap");
    do_op(0, 32'd5, 32'd3, 4'b1001, 32'd0, "t5_bad_op");
    do_op(1, 32'h0000_00F0, 32'h24, 4'b0001, 32'h0000_0F00, "t5_sll");
    do_op(0, 32'h8000_0000, 32'd31, 4'b0101, 32'd1, "t5_srl");
    do_op(1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0111, 32'h00F0_1200, "t5_and");

    // T6: perf counters 3 / 1 / 4
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) do_op(0, 32'd1, 32'd2, 4'b0110, 32'd3, "t6_or");
    resp_ready = 1'b0;
    set_req(1, 32'd1, 32'd1, 4'b0000);
    req_valid[1] = 1'b1;
    wait_ready(1, "t6");
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 32'd0, 32'd0, 4'b0000);
    req_valid[0] = 1'b1;
    repeat (4) tick();
    req_valid[0] = 1'b0;
    resp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_grant0", 64'(perf_grant_cnt[31:0]), PERF_ON ? 64'd3 : 64'd0);
    chk("t6_grant1", 64'(perf_grant_cnt[63:32]), PERF_ON ? 64'd1 : 64'd0);
    chk("t6_stall", 64'(perf_stall_cnt), PERF_ON ? 64'd4 : 64'd0);
    tick();

    // Random traffic; every cycle is checked by the model above.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_req(i, rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
